// File: rtl/fpu_flag_monitor.sv
// fpu_flag_monitor: watches FPU status flags and checks that every special-case
// result implied by the issued operands is flagged within a bounded latency
// window. Expectations are held in order; only the oldest one is evaluated.
module fpu_flag_monitor #(
  parameter int FP_W    = 32,
  parameter int DEPTH   = 4,
  parameter int MIN_LAT = 2,
  parameter int MAX_LAT = 10,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     chk_en,
  input  logic                     clr,
  input  logic                     issue_valid,
  input  logic [FP_W-1:0]          opa,
  input  logic [FP_W-1:0]          opb,
  input  logic [2:0]               fpu_op,
  input  logic                     zero,
  input  logic                     inf,
  input  logic                     qnan,
  input  logic                     div_by_zero,
  input  logic                     overflow,
  input  logic                     underflow,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     err_timeout,
  output logic                     err_drop,
  output logic                     err_mutex,
  output logic [3:0]               err_class
);

  localparam int EXP_W = (FP_W == 64) ? 11 : 8;
  localparam int MAN_W = FP_W - 1 - EXP_W;
  localparam int TS_W  = $clog2(MAX_LAT) + 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;

  localparam logic [TS_W-1:0] MIN_L = TS_W'(MIN_LAT);
  localparam logic [TS_W-1:0] MAX_L = TS_W'(MAX_LAT);
  localparam logic [PW-1:0]   FULL  = PW'(DEPTH);

  // Expectation code: {valid, class}; class index matches err_class bit order.
  localparam logic [2:0] E_NONE = 3'b000;
  localparam logic [2:0] E_ZERO = 3'b100;
  localparam logic [2:0] E_INF  = 3'b101;
  localparam logic [2:0] E_QNAN = 3'b110;
  localparam logic [2:0] E_DBZ  = 3'b111;

  logic             a_zero, a_inf, a_nan;
  logic             b_zero, b_inf, b_nan;
  logic             mag_eq, eff_sub;
  logic [2:0]       exp_code;

  logic [3:0]       flags, flags_q, rise;
  logic [TS_W-1:0]  ts_now;

  logic [1:0]       cls_mem [DEPTH];
  logic [TS_W-1:0]  ts_mem  [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [PW-1:0]    count;

  logic             head_valid, in_window, hit, timeout, pop;
  logic             push_req, full, push, drop;
  logic [1:0]       head_cls;
  logic [TS_W-1:0]  head_lat;

  // Classify operands by magnitude and derive the expected special-case flag.
  always_comb begin
    a_zero   = (opa[FP_W-2 -: EXP_W] == '0) && (opa[MAN_W-1:0] == '0);
    a_inf    = (opa[FP_W-2 -: EXP_W] == '1) && (opa[MAN_W-1:0] == '0);
    a_nan    = (opa[FP_W-2 -: EXP_W] == '1) && (opa[MAN_W-1:0] != '0);
    b_zero   = (opb[FP_W-2 -: EXP_W] == '0) && (opb[MAN_W-1:0] == '0);
    b_inf    = (opb[FP_W-2 -: EXP_W] == '1) && (opb[MAN_W-1:0] == '0);
    b_nan    = (opb[FP_W-2 -: EXP_W] == '1) && (opb[MAN_W-1:0] != '0);
    mag_eq   = (opa[FP_W-2:0] == opb[FP_W-2:0]);
    eff_sub  = (opa[FP_W-1] ^ opb[FP_W-1]) ^ (fpu_op == 3'b001);
    exp_code = E_NONE;
    if (!(a_nan || b_nan)) begin
      case (fpu_op)
        3'b011: begin
          if (a_zero && b_zero)      exp_code = E_QNAN;
          else if (b_zero)           exp_code = E_DBZ;
          else if (a_inf && b_inf)   exp_code = E_QNAN;
          else if (a_zero)           exp_code = E_ZERO;
          else if (a_inf)            exp_code = E_INF;
        end
        3'b010: begin
          if ((a_zero && b_inf) || (a_inf && b_zero)) exp_code = E_QNAN;
          else if (a_zero || b_zero) exp_code = E_ZERO;
          else if (a_inf || b_inf)   exp_code = E_INF;
        end
        3'b000, 3'b001: begin
          if (a_inf && b_inf)        exp_code = eff_sub ? E_QNAN : E_INF;
          else if (a_inf || b_inf)   exp_code = E_INF;
          else if (mag_eq && eff_sub) exp_code = E_ZERO;
        end
        default: exp_code = E_NONE;
      endcase
    end
  end

  // Head evaluation, pop decision and push/drop arbitration.
  always_comb begin
    flags      = {div_by_zero, qnan, inf, zero};
    rise       = flags & ~flags_q;
    head_valid = (count != '0);
    head_cls   = cls_mem[rd_ptr];
    head_lat   = ts_now - ts_mem[rd_ptr];
    in_window  = (head_lat >= MIN_L) && (head_lat <= MAX_L);
    hit        = head_valid && rise[head_cls] && in_window;
    timeout    = head_valid && !hit && (head_lat == MAX_L);
    pop        = hit || timeout;
    push_req   = issue_valid && chk_en && exp_code[2];
    full       = (count == FULL);
    // A pop in the same cycle frees the slot the push needs.
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    pending    = count;
  end

  // Free-running timestamp and previous-edge flag copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_now  <= '0;
      flags_q <= '0;
    end else begin
      ts_now  <= ts_now + TS_W'(1);
      flags_q <= flags;
    end
  end

  // Queue pointers, counters and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
      err_mutex   <= 1'b0;
      err_class   <= '0;
    end else if (clr) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
      err_mutex   <= 1'b0;
      err_class   <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count <= count + PW'(push) - PW'(pop);
      if (hit && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (timeout) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
        err_timeout         <= 1'b1;
        err_class[head_cls] <= 1'b1;
      end
      if (drop) err_drop <= 1'b1;
      if (overflow && underflow) err_mutex <= 1'b1;
    end
  end

  // Expectation storage; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      cls_mem[wr_ptr] <= exp_code[1:0];
      ts_mem[wr_ptr]  <= ts_now;
    end
  end

endmodule

// File: tb/tb_fpu_flag_monitor.sv
// Bench for fpu_flag_monitor: directed scenarios plus randomized traffic,
// all checked against a cycle-count based reference model through a
// per-cycle scoreboard, with extra explicit checks at key points.
module tb_fpu_flag_monitor;

  localparam int FP_W    = 32;
  localparam int DEPTH   = 4;
  localparam int MIN_LAT = 2;
  localparam int MAX_LAT = 10;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n, chk_en, clr, issue_valid;
  logic [FP_W-1:0]   opa, opb;
  logic [2:0]        fpu_op;
  logic              zero, inf, qnan, div_by_zero, overflow, underflow;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt;
  logic [$clog2(DEPTH):0] pending;
  logic              err_timeout, err_drop, err_mutex;
  logic [3:0]        err_class;

  fpu_flag_monitor #(
    .FP_W(FP_W), .DEPTH(DEPTH), .MIN_LAT(MIN_LAT), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr(clr), .issue_valid(issue_valid),
    .opa(opa), .opb(opb), .fpu_op(fpu_op), .zero(zero), .inf(inf), .qnan(qnan),
    .div_by_zero(div_by_zero), .overflow(overflow), .underflow(underflow),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .pending(pending),
    .err_timeout(err_timeout), .err_drop(err_drop), .err_mutex(err_mutex),
    .err_class(err_class)
  );

  always #5 clk = ~clk;

  typedef struct { int c; longint t; } ent_t;
  typedef struct {
    int unsigned pass, fail, pend;
    bit to, dr, mu;
    bit [3:0] cl;
  } snap_t;

  ent_t  mq[$];
  snap_t sbq[$];

  int unsigned m_pass, m_fail;
  bit          m_to, m_dr, m_mu;
  bit [3:0]    m_cl, m_prev;
  longint      m_cyc;

  int tests = 0;
  int fails = 0;

  // Expected flag for an issued operation: -1 none, else 0 zero, 1 inf, 2 qnan, 3 div_by_zero.
  function automatic int ref_class(bit [31:0] a, bit [31:0] b, bit [2:0] op);
    bit az, ai, an, bz, bi, bn, es;
    az = (a[30:0] == 31'd0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    an = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bz = (b[30:0] == 31'd0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (an || bn) return -1;
    case (op)
      3'd3: begin
        if (az && bz) return 2;
        if (bz)       return 3;
        if (ai && bi) return 2;
        if (az)       return 0;
        if (ai)       return 1;
        return -1;
      end
      3'd2: begin
        if ((az && bi) || (ai && bz)) return 2;
        if (az || bz) return 0;
        if (ai || bi) return 1;
        return -1;
      end
      3'd0, 3'd1: begin
        es = (a[31] != b[31]) ^ (op == 3'd1);
        if (ai && bi) return es ? 2 : 1;
        if (ai || bi) return 1;
        if (es && (a[30:0] == b[30:0])) return 0;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic snap_t cur_snap();
    snap_t s;
    s.pass = m_pass; s.fail = m_fail; s.pend = mq.size();
    s.to = m_to; s.dr = m_dr; s.mu = m_mu; s.cl = m_cl;
    return s;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_pass = 0; m_fail = 0;
    m_to = 0; m_dr = 0; m_mu = 0; m_cl = '0;
  endtask

  // Apply one cycle of stimulus, advance the model over the coming edge, queue the expectation.
  task automatic drive_cycle(input bit ce, input bit cl, input bit iv, input bit [31:0] a,
                             input bit [31:0] b, input bit [2:0] op, input bit [3:0] fl,
                             input bit ov, input bit un);
    bit [3:0] rise;
    longint   lat;
    int       c;
    snap_t    s;
    chk_en = ce; clr = cl; issue_valid = iv; opa = a; opb = b; fpu_op = op;
    zero = fl[0]; inf = fl[1]; qnan = fl[2]; div_by_zero = fl[3];
    overflow = ov; underflow = un;
    rise = fl & ~m_prev;
    if (cl) begin
      model_clear();
    end else begin
      if (mq.size() > 0) begin
        lat = m_cyc - mq[0].t;
        if (rise[mq[0].c] && lat >= MIN_LAT && lat <= MAX_LAT) begin
          void'(mq.pop_front());
          if (m_pass < CNT_MAX) m_pass++;
        end else if (lat == MAX_LAT) begin
          m_cl[mq[0].c] = 1'b1;
          m_to = 1'b1;
          void'(mq.pop_front());
          if (m_fail < CNT_MAX) m_fail++;
        end
      end
      if (ov && un) m_mu = 1'b1;
      if (iv && ce) begin
        c = ref_class(a, b, op);
        if (c >= 0) begin
          if (mq.size() < DEPTH) mq.push_back('{c, m_cyc});
          else m_dr = 1'b1;
        end
      end
    end
    m_prev = fl;
    m_cyc++;
    s = cur_snap();
    @(posedge clk);
    #1;
    sbq.push_back(s);
  endtask

  task automatic idle(input int n, input bit [3:0] fl);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0, fl, 1'b0, 1'b0);
  endtask

  task automatic do_clr();
    drive_cycle(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 3'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zeros(input string tag);
    check({tag, "_pass"}, pass_cnt, 0);
    check({tag, "_fail"}, fail_cnt, 0);
    check({tag, "_pending"}, pending, 0);
    check({tag, "_errs"}, {err_timeout, err_drop, err_mutex, err_class}, 0);
  endtask

  // Asynchronous reset between clock edges.
  task automatic do_reset();
    snap_t s;
    @(negedge clk);
    #1;
    chk_en = 1'b1; clr = 1'b0; issue_valid = 1'b0; fpu_op = 3'd0; opa = '0; opb = '0;
    zero = 0; inf = 0; qnan = 0; div_by_zero = 0; overflow = 0; underflow = 0;
    rst_n = 1'b0;
    model_clear();
    m_prev = '0;
    #1;
    check_zeros("async_reset");
    s = cur_snap();
    sbq.push_back(s);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: one expected snapshot per driven edge.
  always @(negedge clk) begin
    snap_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      tests++;
      if (int'(pass_cnt) != e.pass || int'(fail_cnt) != e.fail || int'(pending) != e.pend ||
          err_timeout != e.to || err_drop != e.dr || err_mutex != e.mu || err_class != e.cl) begin
        fails++;
        $display("FAIL scoreboard @%0t: got pass=%0d fail=%0d pend=%0d to=%0b drop=%0b mutex=%0b cls=%b, expected pass=%0d fail=%0d pend=%0d to=%0b drop=%0b mutex=%0b cls=%b",
                 $time, pass_cnt, fail_cnt, pending, err_timeout, err_drop, err_mutex, err_class,
                 e.pass, e.fail, e.pend, e.to, e.dr, e.mu, e.cl);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [31:0] pool [8];
    pool[0] = 32'h0000_0000; pool[1] = 32'h8000_0000; pool[2] = 32'h7F80_0000;
    pool[3] = 32'hFF80_0000; pool[4] = 32'h7FC0_0000; pool[5] = 32'h3F80_0000;
    pool[6] = 32'hBF80_0000; pool[7] = 32'h4000_0000;

    rst_n = 1'b0; chk_en = 1'b1; clr = 1'b0; issue_valid = 1'b0;
    opa = '0; opb = '0; fpu_op = 3'd0;
    zero = 0; inf = 0; qnan = 0; div_by_zero = 0; overflow = 0; underflow = 0;
    model_clear();
    m_prev = '0; m_cyc = 0;
    #12;
    check_zeros("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // div 1.0 / 0 -> div_by_zero flagged at latency 3
    drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd0, 0, 0);
    idle(2, 4'd0);
    idle(1, 4'b1000);
    check("dbz_pass", pass_cnt, 1);
    check("dbz_fail", fail_cnt, 0);
    check("dbz_pending", pending, 0);
    idle(1, 4'd0);

    // +inf + -inf -> qnan never flagged -> timeout exactly at MAX_LAT
    do_clr();
    drive_cycle(1, 0, 1, 32'h7F80_0000, 32'hFF80_0000, 3'd0, 4'd0, 0, 0);
    idle(MAX_LAT - 1, 4'd0);
    check("qnan_pending_before_max", pending, 1);
    check("qnan_fail_before_max", fail_cnt, 0);
    idle(1, 4'd0);
    check("qnan_fail", fail_cnt, 1);
    check("qnan_timeout", err_timeout, 1);
    check("qnan_class", err_class, 4'b0100);

    // 0 * 2.0 -> zero rising at latency 1 is too early, then timeout
    do_clr();
    drive_cycle(1, 0, 1, 32'h0000_0000, 32'h4000_0000, 3'd2, 4'd0, 0, 0);
    idle(1, 4'b0001);
    idle(MAX_LAT - 2, 4'd0);
    check("early_pending", pending, 1);
    idle(1, 4'd0);
    check("early_fail", fail_cnt, 1);
    check("early_pass", pass_cnt, 0);
    check("early_class", err_class, 4'b0001);

    // rise exactly at MAX_LAT still passes
    do_clr();
    drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd0, 0, 0);
    idle(MAX_LAT - 1, 4'd0);
    idle(1, 4'b1000);
    check("maxlat_pass", pass_cnt, 1);
    check("maxlat_fail", fail_cnt, 0);
    idle(1, 4'd0);

    // five x-x subtractions into a 4-deep queue -> drop
    do_clr();
    for (int i = 0; i < 5; i++) drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h3F80_0000, 3'd1, 4'd0, 0, 0);
    check("full_pending", pending, 4);
    check("full_drop", err_drop, 1);

    // full queue: pop and push in the same cycle both succeed
    do_clr();
    for (int i = 0; i < 4; i++) drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h3F80_0000, 3'd1, 4'd0, 0, 0);
    drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h3F80_0000, 3'd1, 4'b0001, 0, 0);
    check("pushpop_pending", pending, 4);
    check("pushpop_pass", pass_cnt, 1);
    check("pushpop_drop", err_drop, 0);

    // chk_en low blocks pushes but the queue still drains; rise at MIN_LAT passes
    do_clr();
    drive_cycle(0, 0, 1, 32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd0, 0, 0);
    check("chken_blocked", pending, 0);
    drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd0, 0, 0);
    drive_cycle(0, 0, 1, 32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd0, 0, 0);
    drive_cycle(0, 0, 0, 32'h0, 32'h0, 3'd0, 4'b1000, 0, 0);
    check("chken_drain_pass", pass_cnt, 1);
    check("chken_drain_pending", pending, 0);
    idle(1, 4'd0);

    // overflow with underflow -> sticky mutex error, even with chk_en low
    do_clr();
    drive_cycle(0, 0, 0, 32'h0, 32'h0, 3'd0, 4'd0, 1, 1);
    check("mutex_set", err_mutex, 1);
    idle(3, 4'd0);
    check("mutex_sticky", err_mutex, 1);
    do_clr();
    check("mutex_clr", err_mutex, 0);

    // pass counter saturates
    for (int i = 0; i < CNT_MAX + 2; i++) begin
      drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd0, 0, 0);
      idle(1, 4'd0);
      idle(1, 4'b1000);
    end
    check("pass_saturate", pass_cnt, CNT_MAX);
    idle(1, 4'd0);

    // reset mid-window discards pending entries
    do_clr();
    drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd0, 0, 0);
    drive_cycle(1, 0, 1, 32'h3F80_0000, 32'h0000_0000, 3'd3, 4'd0, 0, 0);
    idle(2, 4'd0);
    check("prereset_pending", pending, 2);
    do_reset();
    idle(1, 4'b1000);
    idle(3, 4'd0);
    check("postreset_pass", pass_cnt, 0);
    check("postreset_fail", fail_cnt, 0);
    check("postreset_pending", pending, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit [3:0] fl;
      fl[0] = ($urandom_range(0, 3) == 0);
      fl[1] = ($urandom_range(0, 3) == 0);
      fl[2] = ($urandom_range(0, 3) == 0);
      fl[3] = ($urandom_range(0, 3) == 0);
      drive_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
                  pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)], 3'($urandom_range(0, 4)),
                  fl, $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
    end
    idle(MAX_LAT + 2, 4'd0);
    check("final_pass", pass_cnt, m_pass);
    check("final_fail", fail_cnt, m_fail);
    check("final_pending", pending, 0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_flag_monitor.md
FPU_FLAG_MONITOR -- requirements
Module: fpu_flag_monitor

Interface
REQ-001 Parameter FP_W, default 32: operand width; legal values 32 (EXP_W=8) and 64 (EXP_W=11); MAN_W = FP_W-1-EXP_W.
REQ-002 Parameter DEPTH, default 4: outstanding-expectation capacity; power of 2, 2..16.
REQ-003 Parameter MIN_LAT, default 2: minimum legal issue-to-flag latency in cycles; range 1..MAX_LAT.
REQ-004 Parameter MAX_LAT, default 10: maximum legal issue-to-flag latency in cycles; range MIN_LAT..255.
REQ-005 Parameter CNT_W, default 16: pass/fail counter width.
REQ-006 clk  in  1  the only clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 chk_en  in  1  enables capture of new expectations.
REQ-009 clr  in  1  synchronous clear of queue, counters and sticky errors.
REQ-010 issue_valid  in  1  operation issued to the FPU this cycle.
REQ-011 opa, opb  in  FP_W  issued operands.
REQ-012 fpu_op  in  3  000 add, 001 sub, 010 mul, 011 div; other codes produce no expectation.
REQ-013 zero, inf, qnan, div_by_zero, overflow, underflow  in  1 each  FPU status flags.
REQ-014 pass_cnt, fail_cnt  out  CNT_W  saturating counts of matched / failed expectations.
REQ-015 pending  out  clog2(DEPTH)+1  current queue occupancy.
REQ-016 err_timeout, err_drop, err_mutex  out  1 each  sticky error flags.
REQ-017 err_class  out  4  sticky per-class failure, bit order {div_by_zero, qnan, inf, zero}.

Function
REQ-018 Operand classes use magnitude only (sign ignored): ZERO = exponent and mantissa 0; INF = exponent all ones, mantissa 0; NAN = exponent all ones, mantissa nonzero.
REQ-019 Any NAN operand -> no expectation.
REQ-020 div: both ZERO -> qnan; opb ZERO -> div_by_zero; both INF -> qnan; opa ZERO -> zero; opa INF -> inf; else none.
REQ-021 mul: ZERO with INF (either order) -> qnan; either ZERO -> zero; either INF -> inf; else none.
REQ-022 add/sub: effective-subtract = (sign differ XOR op==sub); both INF -> qnan if effective-subtract, else inf; one INF -> inf; equal magnitudes with effective-subtract -> zero; else none.
REQ-023 On issue_valid=1, chk_en=1 with an expectation: push {class, timestamp} into an in-order FIFO.
REQ-024 A free-running timestamp counter of clog2(MAX_LAT)+2 bits; latency = (now - entry timestamp) modulo 2^width; wrap-around shall not affect results.
REQ-025 A flag rise is flag=1 this edge and 0 the previous edge (registered copy).
REQ-026 Only the head entry is evaluated: its flag rises with MIN_LAT <= latency <= MAX_LAT -> pop, pass_cnt+1.
REQ-027 Head latency == MAX_LAT without matching rise -> pop, fail_cnt+1, err_timeout=1, err_class bit of head class set.
REQ-028 Flag rises outside the window or for a non-head class are ignored.
REQ-029 Push when full with no pop in the same cycle -> entry discarded, err_drop=1; push and pop in the same cycle when full both succeed.
REQ-030 overflow=1 and underflow=1 on the same edge -> err_mutex=1, independent of chk_en.
REQ-031 chk_en=0 blocks pushes only; the queue continues to drain and be evaluated.
REQ-032 Counters saturate at all ones.
REQ-033 clr=1 empties the queue and zeroes counters and sticky flags; clr has priority over a same-cycle push or pop.

Reset
REQ-034 rst_n=0 immediately forces pass_cnt=0, fail_cnt=0, pending=0, all err_* = 0, timestamp=0 and registered flag copies = 0.
REQ-035 Reset asserted mid-operation discards all pending expectations, with no pass or fail recorded.

Verification
REQ-036 div, opa=0x3F800000, opb=0x00000000; div_by_zero rises 3 cycles later -> pass_cnt=1, fail_cnt=0, pending=0.
REQ-037 add, opa=0x7F800000, opb=0xFF800000; qnan never rises -> at latency 10, fail_cnt=1, err_timeout=1, err_class=4'b0100.
REQ-038 mul, opa=0x00000000, opb=0x40000000; zero rises at latency 1 -> ignored; timeout at latency 10 -> fail_cnt=1, err_class=4'b0001.
REQ-039 DEPTH=4; five back-to-back sub issues with opa=opb=0x3F800000 and no flags -> pending=4, err_drop=1.
REQ-040 overflow=1 and underflow=1 for one cycle -> err_mutex=1 and stays 1 until clr or reset.
REQ-041 Two pending entries, then rst_n pulsed low mid-window -> pending=0, pass_cnt=0, fail_cnt=0; a later flag rise changes nothing.
